// File: rtl/scroll_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scroll_addr_gen                                                 |
// | Brief    : Scrolled frame-buffer read-burst address generator.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module scroll_addr_gen #(
    parameter int V_ACTIVE = 480,
    parameter int BURSTS   = 10
) (
    input  logic       PixelClk2,
    input  logic       Reset,
    input  logic       VSync,
    input  logic       LineStart,
    input  logic [5:0] XOffsetData,
    input  logic [9:0] YOffsetData,
    input  logic       OffsetWrite,
    output logic       ReqValid,
    input  logic       ReqAck,
    output logic [9:0] ReqRow,
    output logic [5:0] ReqCol,
    output logic       ReqLast,
    output logic       Overrun
);

    // Line counter is at least 10 bits so its low bits feed the row adder directly.
    localparam int               c_LCW_RAW = $clog2(V_ACTIVE + 1);
    localparam int               c_LCW     = (c_LCW_RAW > 10) ? c_LCW_RAW : 10;
    localparam logic [c_LCW-1:0] c_VACT    = c_LCW'(V_ACTIVE);
    localparam logic [5:0]       c_BLAST   = 6'(BURSTS - 1);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_WAIT_LINE  = 2'd1;
    localparam logic [1:0] c_REQ        = 2'd2;
    localparam logic [1:0] c_DONE_FRAME = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic             r_vs_hist;
    logic [5:0]       r_pendx;
    logic [9:0]       r_pendy;
    logic [5:0]       r_actx;
    logic [9:0]       r_acty;
    logic [c_LCW-1:0] r_linecnt;
    logic [5:0]       r_burstcnt;
    logic             r_restart;
    logic             r_reqvalid;
    logic [9:0]       r_reqrow;
    logic [5:0]       r_reqcol;
    logic             r_reqlast;
    logic             r_overrun;

    logic             w_fs;
    logic             w_acc;
    logic             w_start_line;
    logic             w_exit_line;
    logic [5:0]       w_burst_nx;
    logic [9:0]       w_row;

    assign w_fs       = r_vs_hist & ~VSync;
    assign w_acc      = r_reqvalid & ReqAck;
    assign w_burst_nx = r_burstcnt + 6'd1;
    assign w_row      = r_acty + r_linecnt[9:0];

    always_comb begin
        w_state_nx   = r_state;
        w_start_line = 1'b0;
        w_exit_line  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_fs) w_state_nx = c_WAIT_LINE;
            end
            c_WAIT_LINE: begin
                // A frame start restarts the count and wins over a coincident LineStart.
                if (!w_fs && LineStart) begin
                    if (r_linecnt < c_VACT) begin
                        w_state_nx   = c_REQ;
                        w_start_line = 1'b1;
                    end else begin
                        w_state_nx = c_DONE_FRAME;
                    end
                end
            end
            c_REQ: begin
                if (w_acc && (r_reqlast || r_restart || w_fs)) begin
                    w_state_nx  = c_WAIT_LINE;
                    w_exit_line = 1'b1;
                end
            end
            c_DONE_FRAME: begin
                if (w_fs) w_state_nx = c_WAIT_LINE;
            end
            default: w_state_nx = c_IDLE;
        endcase
    end

    always_ff @(posedge PixelClk2) begin
        if (Reset) r_state <= c_IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge PixelClk2) begin
        if (Reset) begin
            r_vs_hist  <= 1'b0;
            r_pendx    <= '0;
            r_pendy    <= '0;
            r_actx     <= '0;
            r_acty     <= '0;
            r_linecnt  <= '0;
            r_burstcnt <= '0;
            r_restart  <= 1'b0;
            r_reqvalid <= 1'b0;
            r_reqrow   <= '0;
            r_reqcol   <= '0;
            r_reqlast  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_vs_hist <= VSync;
            if (OffsetWrite) begin
                r_pendx <= XOffsetData;
                r_pendy <= YOffsetData;
            end
            if (w_fs) begin
                r_actx    <= OffsetWrite ? XOffsetData : r_pendx;
                r_acty    <= OffsetWrite ? YOffsetData : r_pendy;
                r_linecnt <= '0;
            end
            if (LineStart && (r_state == c_REQ)) r_overrun <= 1'b1;

            if (w_start_line) begin
                r_burstcnt <= '0;
                r_restart  <= 1'b0;
                r_reqvalid <= 1'b1;
                r_reqrow   <= w_row;
                r_reqcol   <= r_actx;
                r_reqlast  <= (c_BLAST == 6'd0);
            end else if (w_exit_line) begin
                r_reqvalid <= 1'b0;
                r_reqlast  <= 1'b0;
                r_restart  <= 1'b0;
                // An aborted line leaves the counter at the zero a frame start gave it.
                if (!r_restart && !w_fs) r_linecnt <= r_linecnt + c_LCW'(1);
            end else if (r_state == c_REQ) begin
                if (w_acc) begin
                    r_burstcnt <= w_burst_nx;
                    r_reqcol   <= r_actx + w_burst_nx;
                    r_reqlast  <= (w_burst_nx == c_BLAST);
                end
                if (w_fs) r_restart <= 1'b1;
            end
        end
    end

    assign ReqValid = r_reqvalid;
    assign ReqRow   = r_reqrow;
    assign ReqCol   = r_reqcol;
    assign ReqLast  = r_reqlast;
    assign Overrun  = r_overrun;

endmodule
`default_nettype wire

// File: doc/scroll_addr_gen.md
SCROLL_ADDR_GEN -- requirements
Module: scroll_addr_gen

Interface
REQ-001 The block SHALL have parameter V_ACTIVE, default 480, giving the number of active lines per frame.
REQ-002 The block SHALL have parameter BURSTS, default 10, giving the number of read bursts requested per active line (range 1..64).
REQ-003 Port PixelClk2  input  1  the single clock; all logic SHALL update on its rising edge only.
REQ-004 Port Reset  input  1  synchronous reset, active-high, sampled on the PixelClk2 rising edge.
REQ-005 Port VSync  input  1  frame sync, active-high; its 1->0 transition marks frame start.
REQ-006 Port LineStart  input  1  one-cycle pulse at the start of each line.
REQ-007 Port XOffsetData  input  6  new horizontal scroll offset, in burst columns.
REQ-008 Port YOffsetData  input  10  new vertical scroll offset, in RAM rows.
REQ-009 Port OffsetWrite  input  1  while high, XOffsetData/YOffsetData are valid; it is high for at least one rising edge.
REQ-010 Port ReqValid  output  1  a read-burst request is presented.
REQ-011 Port ReqAck  input  1  the request is accepted on an edge where ReqValid and ReqAck are both high.
REQ-012 Port ReqRow  output  10  RAM row of the request.
REQ-013 Port ReqCol  output  6  RAM burst column of the request.
REQ-014 Port ReqLast  output  1  high with the last request of a line.
REQ-015 Port Overrun  output  1  sticky error flag: a LineStart arrived while the previous line was unfinished.

Function
REQ-016 Offset writes: a sampled OffsetWrite=1 SHALL load PendX/PendY from XOffsetData/YOffsetData; repeated writes overwrite the pending value.
REQ-017 Frame start: frame start SHALL be detected as VSync 1 on the previous sample and 0 now (a registered edge detector); on this edge ActX<=PendX, ActY<=PendY, and LineCnt<=0.
REQ-018 OffsetWrite and frame start on the same edge: the incoming XOffsetData/YOffsetData SHALL go straight to ActX/ActY (bypass) and to PendX/PendY.
REQ-019 The state machine SHALL have the states IDLE, WAIT_LINE, REQ and DONE_FRAME.
REQ-020 IDLE: wait for frame start, then go to WAIT_LINE.
REQ-021 WAIT_LINE: on LineStart with LineCnt<V_ACTIVE, set BurstCnt=0 and go to REQ.
REQ-022 WAIT_LINE: on LineStart with LineCnt>=V_ACTIVE, go to DONE_FRAME.
REQ-023 REQ: ReqValid=1; ReqRow=(ActY+LineCnt) mod 1024; ReqCol=(ActX+BurstCnt) mod 64; ReqLast=1 when BurstCnt=BURSTS-1.
REQ-024 REQ: outputs SHALL be registered and SHALL hold stable while ReqValid=1 and ReqAck=0.
REQ-025 REQ, on acceptance of a non-last request: BurstCnt increments, and the next request SHALL be presented on the following cycle (no bubble required).
REQ-026 REQ, on acceptance of the last request: ReqValid drops next cycle, LineCnt increments, and the state goes to WAIT_LINE.
REQ-027 DONE_FRAME: ignore LineStart; go to WAIT_LINE on frame start.
REQ-028 LineStart in REQ SHALL be ignored and SHALL set Overrun=1; Overrun clears only on Reset.
REQ-029 Frame start in REQ: the presented request SHALL NOT be withdrawn; after its acceptance the state goes to WAIT_LINE with LineCnt=0 and the new ActX/ActY, and no further bursts of the old line are issued.
REQ-030 Arithmetic SHALL wrap silently: rows modulo 1024 and columns modulo 64, with no saturation.
REQ-031 ReqAck while ReqValid=0 SHALL be ignored.

Reset
REQ-032 With Reset=1, on the next rising edge the block SHALL set: state IDLE; ReqValid=0, ReqRow=0, ReqCol=0, ReqLast=0, Overrun=0.
REQ-033 With Reset=1, on the next rising edge the block SHALL also clear PendX, PendY, ActX, ActY, LineCnt, BurstCnt and the VSync history register (history=0).
REQ-034 Reset SHALL take priority over every other input, including in the middle of a handshake; the first frame start after reset is needed before any request is issued.

Verification
REQ-035 Basic line: Pend=(X=5, Y=100), frame start, LineStart, ReqAck held at 1 -> 10 consecutive requests, row 100, cols 5..14, ReqLast on col 14.
REQ-036 Wrap: X=60, Y=1023, BURSTS=10; line 0 then line 1 -> line 0 is row 1023 with cols 60,61,62,63,0..5; line 1 is row 0.
REQ-037 Backpressure: ReqAck low for 3 cycles on the 2nd request -> ReqRow/ReqCol/ReqLast stay stable and no request is lost or duplicated.
REQ-038 Offset timing: OffsetWrite(X=7) mid-frame -> current frame keeps the old X; next frame uses 7; a write on the frame-start edge applies immediately.
REQ-039 Overrun and frame end: LineStart during REQ -> Overrun=1 and the line is unaffected; after V_ACTIVE lines, further LineStart pulses produce no requests.
REQ-040 Reset mid-handshake: Reset=1 while ReqValid=1 -> next cycle ReqValid=0 and Overrun=0; no requests until a new VSync 1->0 transition.
